sc_road_engine: RTL and testbench

Parametrised playfield engine for the road-fighter game. It replaces the fixed 8x8 car-register, environment-register, score and level logic with one block. Rows, lanes, level thresholds and scroll periods are set by parameters. The block scrolls a ROWS x COLS environment, moves the one-hot player car on row 0 and detects collisions. It also tracks score, level and game state, and drives a flattened frame bus to the screen selector / matrix path.

---
 rtl/sc_road_engine.sv | 199 +++++++++++++++++++
 tb/tb_sc_road_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sc_road_engine.sv
// Road-fighter playfield engine: scrolls a ROWS x COLS environment, steers a one-hot car on
// row 0, and tracks collision, score, level and game state behind a flattened frame bus.
module sc_road_engine #(
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int SCORE_W    = 8,
   parameter int LVL1_SCORE = 16,
   parameter int LVL2_SCORE = 32,
   parameter int WIN_SCORE  = 64,
   parameter int TICK_L0    = 25000000,
   parameter int TICK_L1    = 12500000,
   parameter int TICK_L2    = 6250000
) (
   input  logic                 SC_ROAD_ENGINE_CLOCK_50,
   input  logic                 SC_ROAD_ENGINE_RESET_InLow,
   input  logic                 SC_ROAD_ENGINE_START_In,
   input  logic                 SC_ROAD_ENGINE_LEFT_In,
   input  logic                 SC_ROAD_ENGINE_RIGHT_In,
   input  logic [COLS-1:0]      SC_ROAD_ENGINE_ROWGEN_InBus,
   output logic [ROWS*COLS-1:0] SC_ROAD_ENGINE_FRAME_OutBus,
   output logic                 SC_ROAD_ENGINE_SCROLL_Out,
   output logic [1:0]           SC_ROAD_ENGINE_STATE_OutBus,
   output logic [1:0]           SC_ROAD_ENGINE_LEVEL_OutBus,
   output logic [SCORE_W-1:0]   SC_ROAD_ENGINE_SCORE_OutBus
);

   localparam int TICK_MAX01 = (TICK_L0 > TICK_L1) ? TICK_L0 : TICK_L1;
   localparam int TICK_MAX   = (TICK_MAX01 > TICK_L2) ? TICK_MAX01 : TICK_L2;
   localparam int TICK_W     = $clog2(TICK_MAX);
   localparam logic [COLS-1:0] CAR_CTR = {{(COLS-1){1'b0}}, 1'b1} << (COLS/2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_LOSE = 2'b10,
      ST_WIN  = 2'b11
   } state_t;

   function automatic logic [1:0] level_of(input logic [SCORE_W-1:0] score);
      logic [1:0] lv;
      if (score < SCORE_W'(LVL1_SCORE)) begin
         lv = 2'd0;
      end else if (score < SCORE_W'(LVL2_SCORE)) begin
         lv = 2'd1;
      end else begin
         lv = 2'd2;
      end
      return lv;
   endfunction

   function automatic logic [TICK_W-1:0] last_tick(input logic [1:0] lv);
      logic [TICK_W-1:0] lt;
      case (lv)
         2'd0:    lt = TICK_W'(TICK_L0 - 1);
         2'd1:    lt = TICK_W'(TICK_L1 - 1);
         default: lt = TICK_W'(TICK_L2 - 1);
      endcase
      return lt;
   endfunction

   state_t                      r_state;
   logic [ROWS-1:0][COLS-1:0]   r_env;
   logic [COLS-1:0]             r_car;
   logic [SCORE_W-1:0]          r_score;
   logic [TICK_W-1:0]           r_tick;
   logic                        r_scroll;
   logic                        r_start_q, r_start_prev;
   logic                        r_left_q, r_left_prev;
   logic                        r_right_q, r_right_prev;

   state_t                      w_state_nxt;
   logic [ROWS-1:0][COLS-1:0]   w_env_nxt;
   logic [COLS-1:0]             w_car_nxt;
   logic [SCORE_W-1:0]          w_score_nxt;
   logic [TICK_W-1:0]           w_tick_nxt;
   logic                        w_scroll_nxt;
   logic                        w_start_edge, w_left_edge, w_right_edge;
   logic                        w_hit, w_win;
   logic [ROWS*COLS-1:0]        w_car_ext;

   assign w_start_edge = r_start_q & ~r_start_prev;
   assign w_left_edge  = r_left_q  & ~r_left_prev;
   assign w_right_edge = r_right_q & ~r_right_prev;
   assign w_hit        = |(r_env[0] & r_car);
   assign w_win        = (r_score == SCORE_W'(WIN_SCORE));

   // Button sample and previous-value registers; resetting to 1 hides a button held through reset.
   always_ff @(posedge SC_ROAD_ENGINE_CLOCK_50 or negedge SC_ROAD_ENGINE_RESET_InLow) begin
      if (!SC_ROAD_ENGINE_RESET_InLow) begin
         r_start_q    <= 1'b1;
         r_start_prev <= 1'b1;
         r_left_q     <= 1'b1;
         r_left_prev  <= 1'b1;
         r_right_q    <= 1'b1;
         r_right_prev <= 1'b1;
      end else begin
         r_start_q    <= SC_ROAD_ENGINE_START_In;
         r_start_prev <= r_start_q;
         r_left_q     <= SC_ROAD_ENGINE_LEFT_In;
         r_left_prev  <= r_left_q;
         r_right_q    <= SC_ROAD_ENGINE_RIGHT_In;
         r_right_prev <= r_right_q;
      end
   end

   // Game FSM next-state, playfield shift, car movement and tick counting.
   always_comb begin
      w_state_nxt = r_state;
      w_env_nxt   = r_env;
      w_car_nxt   = r_car;
      w_score_nxt = r_score;
      w_tick_nxt  = r_tick;
      case (r_state)
         ST_IDLE: begin
            w_env_nxt   = {(ROWS*COLS){1'b0}};
            w_car_nxt   = CAR_CTR;
            w_score_nxt = {SCORE_W{1'b0}};
            w_tick_nxt  = {TICK_W{1'b0}};
            if (w_start_edge) begin
               w_state_nxt = ST_PLAY;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_PLAY: begin
            // r_scroll mirrors (tick >= P-1) for this cycle, so it doubles as the scroll strobe
            if (r_scroll) begin
               w_tick_nxt  = {TICK_W{1'b0}};
               w_score_nxt = r_score + {{(SCORE_W-1){1'b0}}, 1'b1};
               for (int k = 0; k < ROWS-1; k++) begin
                  w_env_nxt[k] = r_env[k+1];
               end
               w_env_nxt[ROWS-1] = SC_ROAD_ENGINE_ROWGEN_InBus;
            end else begin
               w_tick_nxt = r_tick + {{(TICK_W-1){1'b0}}, 1'b1};
            end
            if (w_left_edge && !w_right_edge && !r_car[COLS-1]) begin
               w_car_nxt = {r_car[COLS-2:0], 1'b0};
            end else if (w_right_edge && !w_left_edge && !r_car[0]) begin
               w_car_nxt = {1'b0, r_car[COLS-1:1]};
            end else begin
               w_car_nxt = r_car;
            end
            if (w_hit) begin
               w_state_nxt = ST_LOSE;
            end else if (w_win) begin
               w_state_nxt = ST_WIN;
            end else begin
               w_state_nxt = ST_PLAY;
            end
         end
         ST_LOSE, ST_WIN: begin
            if (w_start_edge) begin
               w_env_nxt   = {(ROWS*COLS){1'b0}};
               w_car_nxt   = CAR_CTR;
               w_score_nxt = {SCORE_W{1'b0}};
               w_tick_nxt  = {TICK_W{1'b0}};
               w_state_nxt = ST_PLAY;
            end else begin
               w_state_nxt = r_state;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Scroll strobe is precomputed from next-cycle state so the output can be a plain flop.
   assign w_scroll_nxt = (w_state_nxt == ST_PLAY) &&
                         (w_tick_nxt >= last_tick(level_of(w_score_nxt)));

   // Game state registers.
   always_ff @(posedge SC_ROAD_ENGINE_CLOCK_50 or negedge SC_ROAD_ENGINE_RESET_InLow) begin
      if (!SC_ROAD_ENGINE_RESET_InLow) begin
         r_state  <= ST_IDLE;
         r_env    <= {(ROWS*COLS){1'b0}};
         r_car    <= CAR_CTR;
         r_score  <= {SCORE_W{1'b0}};
         r_tick   <= {TICK_W{1'b0}};
         r_scroll <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_env    <= w_env_nxt;
         r_car    <= w_car_nxt;
         r_score  <= w_score_nxt;
         r_tick   <= w_tick_nxt;
         r_scroll <= w_scroll_nxt;
      end
   end

   assign w_car_ext                   = {{((ROWS-1)*COLS){1'b0}}, r_car};
   assign SC_ROAD_ENGINE_FRAME_OutBus = r_env | w_car_ext;
   assign SC_ROAD_ENGINE_SCROLL_Out   = r_scroll;
   assign SC_ROAD_ENGINE_STATE_OutBus = r_state;
   assign SC_ROAD_ENGINE_LEVEL_OutBus = level_of(r_score);
   assign SC_ROAD_ENGINE_SCORE_OutBus = r_score;

endmodule

// File: tb/tb_sc_road_engine.sv
// Directed self-checking bench for sc_road_engine on a 4x4 playfield with short scroll periods.
module tb_sc_road_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_in = 1'b0;
   logic        left_in = 1'b0;
   logic        right_in = 1'b0;
   logic [3:0]  rowgen = 4'h0;
   logic [15:0] frame;
   logic        scroll;
   logic [1:0]  state;
   logic [1:0]  level;
   logic [7:0]  score;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0]  rowgen;
      int          gap;
      logic [15:0] frame;
      logic [7:0]  score;
      logic [1:0]  level;
   } vec_t;

   vec_t tbl [6];

   sc_road_engine #(
      .ROWS(4), .COLS(4), .SCORE_W(8),
      .LVL1_SCORE(2), .LVL2_SCORE(4), .WIN_SCORE(6),
      .TICK_L0(4), .TICK_L1(3), .TICK_L2(2)
   ) dut (
      .SC_ROAD_ENGINE_CLOCK_50    (clk),
      .SC_ROAD_ENGINE_RESET_InLow (rst_n),
      .SC_ROAD_ENGINE_START_In    (start_in),
      .SC_ROAD_ENGINE_LEFT_In     (left_in),
      .SC_ROAD_ENGINE_RIGHT_In    (right_in),
      .SC_ROAD_ENGINE_ROWGEN_InBus(rowgen),
      .SC_ROAD_ENGINE_FRAME_OutBus(frame),
      .SC_ROAD_ENGINE_SCROLL_Out  (scroll),
      .SC_ROAD_ENGINE_STATE_OutBus(state),
      .SC_ROAD_ENGINE_LEVEL_OutBus(level),
      .SC_ROAD_ENGINE_SCORE_OutBus(score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-edge button pulse followed by one low edge; its effect is visible on return.
   task automatic pulse(input logic l, input logic r, input logic s);
      left_in = l; right_in = r; start_in = s;
      step(1);
      left_in = 1'b0; right_in = 1'b0; start_in = 1'b0;
      step(1);
   endtask

   // Waits for a scroll pulse, lets it apply, then checks spacing and the resulting frame.
   task automatic run_scroll(input string nm, input logic [3:0] rg, input int exp_gap,
                             input logic [15:0] exp_frame, input logic [7:0] exp_score,
                             input logic [1:0] exp_lvl);
      int g;
      g = 0;
      rowgen = rg;
      do begin
         step(1);
         g++;
      end while (!scroll && g < 50);
      if (!scroll) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: no scroll pulse within %0d cycles", nm, g);
      end
      step(1);
      g++;
      chk({nm, "_gap"},    g, exp_gap);
      chk({nm, "_frame"},  frame, exp_frame);
      chk({nm, "_score"},  score, exp_score);
      chk({nm, "_level"},  level, exp_lvl);
      chk({nm, "_pulse1"}, scroll, 1'b0);
      chk({nm, "_state"},  state, 2'b01);
   endtask

   initial begin
      tbl[0] = '{4'h1, 4, 16'h1004, 8'd1, 2'd0};
      tbl[1] = '{4'h0, 4, 16'h0104, 8'd2, 2'd1};
      tbl[2] = '{4'h0, 3, 16'h0014, 8'd3, 2'd1};
      tbl[3] = '{4'h0, 3, 16'h0005, 8'd4, 2'd2};
      tbl[4] = '{4'h0, 2, 16'h0004, 8'd5, 2'd2};
      tbl[5] = '{4'h2, 2, 16'h2004, 8'd6, 2'd2};

      step(3);
      chk("rst_state", state, 2'b00);
      chk("rst_frame", frame, 16'h0004);
      chk("rst_score", score, 8'd0);
      chk("rst_scroll", scroll, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      step(3);
      chk("idle_state", state, 2'b00);
      pulse(1'b1, 1'b0, 1'b0);
      chk("idle_move_ignored", frame, 16'h0004);

      pulse(1'b0, 1'b0, 1'b1);
      chk("start_state", state, 2'b01);
      chk("start_frame", frame, 16'h0004);
      chk("start_level", level, 2'd0);

      for (int i = 0; i < 6; i++) begin
         run_scroll($sformatf("scrollA%0d", i + 1), tbl[i].rowgen, tbl[i].gap,
                    tbl[i].frame, tbl[i].score, tbl[i].level);
      end
      rowgen = 4'h0;
      step(1);
      chk("win_state", state, 2'b11);
      step(5);
      chk("win_hold_state", state, 2'b11);
      chk("win_hold_score", score, 8'd6);
      chk("win_hold_frame", frame, 16'h2004);

      pulse(1'b0, 1'b0, 1'b1);
      chk("restart_state", state, 2'b01);
      chk("restart_score", score, 8'd0);
      chk("restart_frame", frame, 16'h0004);

      pulse(1'b1, 1'b0, 1'b0);
      chk("left1", frame, 16'h0008);
      pulse(1'b1, 1'b0, 1'b0);
      chk("left2_sat", frame, 16'h0008);
      pulse(1'b1, 1'b0, 1'b0);
      chk("left3_sat", frame, 16'h0008);
      pulse(1'b1, 1'b1, 1'b0);
      chk("left_right_same", frame, 16'h0008);
      pulse(1'b0, 1'b1, 1'b0);
      chk("right1", frame, 16'h0004);
      pulse(1'b0, 1'b1, 1'b0);
      chk("right2", frame, 16'h0002);
      pulse(1'b0, 1'b1, 1'b0);
      chk("right3", frame, 16'h0001);
      pulse(1'b0, 1'b1, 1'b0);
      chk("right4_sat", frame, 16'h0001);
      pulse(1'b0, 1'b0, 1'b1);
      chk("start_in_play_ignored", frame, 16'h0001);

      rst_n = 1'b0;
      start_in = 1'b1;
      #2;
      chk("async_rst_state", state, 2'b00);
      chk("async_rst_frame", frame, 16'h0004);
      chk("async_rst_score", score, 8'd0);
      chk("async_rst_level", level, 2'd0);
      chk("async_rst_scroll", scroll, 1'b0);
      step(2);
      @(negedge clk) rst_n = 1'b1;
      step(5);
      chk("held_start_idle", state, 2'b00);
      start_in = 1'b0;
      step(2);

      pulse(1'b0, 1'b0, 1'b1);
      chk("gameC_state", state, 2'b01);
      run_scroll("scrollC1", 4'h4, 4, 16'h4004, 8'd1, 2'd0);
      run_scroll("scrollC2", 4'h0, 4, 16'h0404, 8'd2, 2'd1);
      run_scroll("scrollC3", 4'h0, 3, 16'h0044, 8'd3, 2'd1);
      run_scroll("scrollC4", 4'h0, 3, 16'h0004, 8'd4, 2'd2);
      step(1);
      chk("lose_state", state, 2'b10);
      step(5);
      pulse(1'b1, 1'b0, 1'b0);
      chk("lose_frame_frozen", frame, 16'h0004);
      chk("lose_score_frozen", score, 8'd4);
      chk("lose_state_hold", state, 2'b10);
      chk("lose_level", level, 2'd2);
      pulse(1'b0, 1'b0, 1'b1);
      chk("lose_restart_state", state, 2'b01);
      chk("lose_restart_score", score, 8'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
